aes_inv_stream_arb: RTL and testbench
=====================================

AES_INV_STREAM_ARB -- requirements
Module: aes_inv_stream_arb

Interface
REQ-001 Parameter TDATA_WIDTH, default 128, width of all tdata buses.
REQ-002 Parameter ID_DEPTH, default 16, power of two, entries in the in-flight source-ID FIFO.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 resetn  input  1  synchronous active-low reset.
REQ-005 s0_tdata, s1_tdata  input  TDATA_WIDTH  ciphertext from requester 0/1.
REQ-006 s0_tvalid, s1_tvalid  input  1  requester beat valid.
REQ-007 s0_tlast, s1_tlast  input  1  last beat of requester packet.
REQ-008 s0_tready, s1_tready  output  1  beat accepted from requester.
REQ-009 round_keys_valid  input  1  key expansion complete; round keys usable.
REQ-010 core_in_tdata  output  TDATA_WIDTH  beat to aes_inv_chiper.
REQ-011 core_in_tvalid, core_in_tlast  output  1  beat valid / last to core.
REQ-012 core_in_tready  input  1  core accepts beat.
REQ-013 core_out_tdata  input  TDATA_WIDTH  plaintext from core.
REQ-014 core_out_tvalid, core_out_tlast  input  1  core output valid / last.
REQ-015 core_out_tready  output  1  backpressure to core.
REQ-016 m0_tdata, m1_tdata  output  TDATA_WIDTH  plaintext to requester 0/1.
REQ-017 m0_tvalid, m1_tvalid, m0_tlast, m1_tlast  output  1  return beat valid / last.
REQ-018 m0_tready, m1_tready  input  1  return-side backpressure.
REQ-019 grant  output  2  one-hot current owner (bit0 = s0, bit1 = s1), 0 when IDLE.
REQ-020 route_err  output  1  sticky: core output arrived with ID FIFO empty.

Function
REQ-021 FSM states IDLE, GRANT0, GRANT1; state and grant registered.
REQ-022 IDLE: when round_keys_valid=1 and ID FIFO not full, SHALL move to GRANTx next cycle for a valid requester; both valid -> the one not equal to last_grant (round-robin).
REQ-023 IDLE SHALL hold all s*_tready=0 and core_in_tvalid=0; first beat transfers no earlier than the cycle after the grant.
REQ-024 GRANTx: core_in_tdata/tlast = sx_tdata/tlast; core_in_tvalid = sx_tvalid & round_keys_valid & !fifo_full.
REQ-025 GRANTx: sx_tready = core_in_tready & round_keys_valid & !fifo_full; non-granted sy_tready=0.
REQ-026 Arbitration only at packet boundaries: accepted beat with tlast=1 in GRANTx -> IDLE next cycle, last_grant<=x.
REQ-027 round_keys_valid falling mid-packet SHALL stall (tready=0, tvalid=0) without losing grant; resumes when it returns.
REQ-028 Each accepted core_in beat SHALL push source ID x into the ID FIFO.
REQ-029 Return routing: head ID h selects mh; mh_tdata/tlast = core_out_tdata/tlast, mh_tvalid = core_out_tvalid & !fifo_empty; other m tvalid=0.
REQ-030 core_out_tready = mh_tready when FIFO non-empty; accepted output beat pops FIFO.
REQ-031 FIFO empty with core_out_tvalid=1: core_out_tready=1 (beat discarded), both m tvalid=0, route_err<=1 until reset.
REQ-032 Simultaneous push and pop SHALL keep occupancy unchanged; full blocks push only (pop still allowed, same cycle full->not full allows push next cycle).
REQ-033 Pointers wrap modulo ID_DEPTH; occupancy counter width log2(ID_DEPTH)+1.
REQ-034 m*_tdata SHALL be a combinational pass-through (zero added latency on return path); input path adds one-cycle grant latency only.

Reset
REQ-035 resetn=0 at a clock edge SHALL set state IDLE, grant=0, last_grant=1 (s0 wins first tie), FIFO empty, route_err=0; hence all s*_tready, core_in_tvalid, m*_tvalid =0 during reset.
REQ-036 Reset mid-packet SHALL abandon the packet and in-flight IDs; no beat is re-issued.

Verification
REQ-037 Keys: round_keys_valid=0, s0_tvalid=1 -> s0_tready=0, grant=0 indefinitely; raise keys -> grant=01 next cycle.
REQ-038 Both requesters send 2-beat packets continuously -> packets alternate s0,s1,s0 with no interleave inside a packet; first grant s0.
REQ-039 s1 sends 4 beats (CT F3EED1BD..., 591CCB10..., B6ED21B9..., 23304B7A... with key 603DEB10...) -> m1 returns 4 beats in order, m0_tvalid never 1.
REQ-040 Hold m0_tready=0 with ID_DEPTH=16: after 16 accepted s0 beats s0_tready=0 until a return beat pops.
REQ-041 Inject core_out_tvalid=1 with empty FIFO -> beat consumed, route_err=1 held until resetn=0.
REQ-042 Assert resetn=0 mid-packet -> next cycle all valids/readies 0, grant=0, FIFO empty.

Source files
------------

// File: rtl/aes_inv_stream_arb_if.sv
// ---------------------------------------------------------------------------
// aes_inv_stream_arb_if
// Bundles every stream/handshake signal around the inverse-cipher arbiter.
//   s0_*/s1_*      : ciphertext request streams (requester -> arbiter)
//   core_in_*      : arbitrated beat stream (arbiter -> cipher core)
//   core_out_*     : plaintext stream (cipher core -> arbiter)
//   m0_*/m1_*      : routed plaintext return streams (arbiter -> requester)
//   round_keys_valid : key expansion complete
//   grant          : one-hot current owner, route_err : sticky underrun flag
// Modport "master" is the arbiter's view; "slave" is the surrounding system.
// ---------------------------------------------------------------------------
interface aes_inv_stream_arb_if #(
    parameter int TDATA_WIDTH = 128
);
    logic [TDATA_WIDTH-1:0] s0_tdata;
    logic                   s0_tvalid;
    logic                   s0_tlast;
    logic                   s0_tready;
    logic [TDATA_WIDTH-1:0] s1_tdata;
    logic                   s1_tvalid;
    logic                   s1_tlast;
    logic                   s1_tready;
    logic                   round_keys_valid;
    logic [TDATA_WIDTH-1:0] core_in_tdata;
    logic                   core_in_tvalid;
    logic                   core_in_tlast;
    logic                   core_in_tready;
    logic [TDATA_WIDTH-1:0] core_out_tdata;
    logic                   core_out_tvalid;
    logic                   core_out_tlast;
    logic                   core_out_tready;
    logic [TDATA_WIDTH-1:0] m0_tdata;
    logic                   m0_tvalid;
    logic                   m0_tlast;
    logic                   m0_tready;
    logic [TDATA_WIDTH-1:0] m1_tdata;
    logic                   m1_tvalid;
    logic                   m1_tlast;
    logic                   m1_tready;
    logic [1:0]             grant;
    logic                   route_err;

    modport master (
        input  s0_tdata, s0_tvalid, s0_tlast,
        input  s1_tdata, s1_tvalid, s1_tlast,
        input  round_keys_valid, core_in_tready,
        input  core_out_tdata, core_out_tvalid, core_out_tlast,
        input  m0_tready, m1_tready,
        output s0_tready, s1_tready,
        output core_in_tdata, core_in_tvalid, core_in_tlast,
        output core_out_tready,
        output m0_tdata, m0_tvalid, m0_tlast,
        output m1_tdata, m1_tvalid, m1_tlast,
        output grant, route_err
    );

    modport slave (
        output s0_tdata, s0_tvalid, s0_tlast,
        output s1_tdata, s1_tvalid, s1_tlast,
        output round_keys_valid, core_in_tready,
        output core_out_tdata, core_out_tvalid, core_out_tlast,
        output m0_tready, m1_tready,
        input  s0_tready, s1_tready,
        input  core_in_tdata, core_in_tvalid, core_in_tlast,
        input  core_out_tready,
        input  m0_tdata, m0_tvalid, m0_tlast,
        input  m1_tdata, m1_tvalid, m1_tlast,
        input  grant, route_err
    );
endinterface

// File: rtl/aes_inv_stream_arb.sv
// ---------------------------------------------------------------------------
// aes_inv_stream_arb
// Shares one inverse-cipher core between two requesters. Whole packets are
// granted round-robin; every beat sent to the core records its source ID in
// a FIFO so the core's output beats are steered back to the right requester.
// Ports:
//   clk    : single rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : aes_inv_stream_arb_if.master (all stream signals, grant,
//            route_err)
// ---------------------------------------------------------------------------
module aes_inv_stream_arb #(
    parameter int TDATA_WIDTH = 128,
    parameter int ID_DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    aes_inv_stream_arb_if.master       bus
);
    localparam int AW = $clog2(ID_DEPTH);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_last_grant;
    logic                   w_last_grant_next;
    logic                   r_route_err;

    logic                   r_id_mem [ID_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_gate;
    logic                   w_src;
    logic                   w_sel_tvalid;
    logic                   w_sel_tlast;
    logic [TDATA_WIDTH-1:0] w_sel_tdata;
    logic                   w_in_tvalid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head;
    logic                   w_s0_tready;
    logic                   w_s1_tready;
    logic                   w_out_tready;
    logic                   w_m0_tvalid;
    logic                   w_m1_tvalid;

    assign w_full  = (r_count == (AW+1)'(ID_DEPTH));
    assign w_empty = (r_count == '0);
    // Keys missing or no room for another ID: stall the input side entirely.
    assign w_gate  = bus.round_keys_valid & ~w_full;

    assign w_src        = (r_state == ST_GRANT1);
    assign w_sel_tvalid = w_src ? bus.s1_tvalid : bus.s0_tvalid;
    assign w_sel_tlast  = w_src ? bus.s1_tlast  : bus.s0_tlast;
    assign w_sel_tdata  = w_src ? bus.s1_tdata  : bus.s0_tdata;
    assign w_push       = w_in_tvalid & bus.core_in_tready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;   // s0 wins the first tie
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_gate) begin
                    if (bus.s0_tvalid && bus.s1_tvalid)
                        w_state_next = r_last_grant ? ST_GRANT0 : ST_GRANT1;
                    else if (bus.s0_tvalid)
                        w_state_next = ST_GRANT0;
                    else if (bus.s1_tvalid)
                        w_state_next = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                // Release only after the packet's last beat is accepted.
                if (w_push && w_sel_tlast) begin
                    w_state_next      = ST_IDLE;
                    w_last_grant_next = w_src;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_tvalid = 1'b0;
        w_s0_tready = 1'b0;
        w_s1_tready = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                w_in_tvalid = bus.s0_tvalid & w_gate;
                w_s0_tready = bus.core_in_tready & w_gate;
            end
            ST_GRANT1: begin
                w_in_tvalid = bus.s1_tvalid & w_gate;
                w_s1_tready = bus.core_in_tready & w_gate;
            end
            default: ;
        endcase
    end

    assign bus.core_in_tdata  = w_sel_tdata;
    assign bus.core_in_tlast  = w_sel_tlast;
    assign bus.core_in_tvalid = w_in_tvalid;
    assign bus.s0_tready      = w_s0_tready;
    assign bus.s1_tready      = w_s1_tready;
    assign bus.grant          = r_state;

    // ---------------- Source-ID FIFO ----------------
    // Storage is unreset; only pointers/occupancy define validity. The head is
    // read asynchronously so the return path adds no latency.
    always_ff @(posedge clk) begin
        if (w_push)
            r_id_mem[r_wr_ptr] <= w_src;
    end

    assign w_head = r_id_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- Return routing ----------------
    always_comb begin
        w_m0_tvalid  = 1'b0;
        w_m1_tvalid  = 1'b0;
        w_out_tready = 1'b1;    // underrun: swallow the stray beat
        if (!w_empty) begin
            w_out_tready = w_head ? bus.m1_tready : bus.m0_tready;
            w_m0_tvalid  = bus.core_out_tvalid & ~w_head;
            w_m1_tvalid  = bus.core_out_tvalid & w_head;
        end
    end

    assign w_pop = ~w_empty & bus.core_out_tvalid & w_out_tready;

    assign bus.core_out_tready = w_out_tready;
    assign bus.m0_tdata        = bus.core_out_tdata;
    assign bus.m0_tlast        = bus.core_out_tlast;
    assign bus.m0_tvalid       = w_m0_tvalid;
    assign bus.m1_tdata        = bus.core_out_tdata;
    assign bus.m1_tlast        = bus.core_out_tlast;
    assign bus.m1_tvalid       = w_m1_tvalid;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_route_err <= 1'b0;
        else if (bus.core_out_tvalid && w_empty)
            r_route_err <= 1'b1;
    end

    assign bus.route_err = r_route_err;

endmodule

// File: tb/tb_aes_inv_stream_arb.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_stream_arb
// Directed bench for aes_inv_stream_arb: reset values, key gating, packet
// round-robin, in-order return routing, stall on key loss, FIFO-full
// backpressure, underrun flag and mid-packet reset.
// ---------------------------------------------------------------------------
module tb_aes_inv_stream_arb;
    localparam int W = 128;

    localparam logic [W-1:0] CT [4] = '{
        128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
        128'h591ccb10d410ed26dc5ba74a31362870,
        128'hb6ed21b99ca6f4f9f153e7b1beafed1d,
        128'h23304b7a39f9f3ff067d8d8f9e24ecc7
    };
    localparam logic [W-1:0] PT [4] = '{
        128'h6bc1bee22e409f96e93d7e117393172a,
        128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef,
        128'hf69f2445df4f9b17ad2b417be66c3710
    };

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    aes_inv_stream_arb_if #(.TDATA_WIDTH(W)) bus ();

    aes_inv_stream_arb #(.TDATA_WIDTH(W), .ID_DEPTH(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_g(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.s0_tdata = '0; bus.s0_tvalid = 1'b0; bus.s0_tlast = 1'b0;
        bus.s1_tdata = '0; bus.s1_tvalid = 1'b0; bus.s1_tlast = 1'b0;
        bus.round_keys_valid = 1'b0;
        bus.core_in_tready   = 1'b0;
        bus.core_out_tdata = '0; bus.core_out_tvalid = 1'b0; bus.core_out_tlast = 1'b0;
        bus.m0_tready = 1'b0; bus.m1_tready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g [8];
        logic       exp_id [4];
        int  b0, b1, n_acc;
        logic a0, a1;

        checks = 0;
        errors = 0;
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        #1;
        chk_g("rst_grant", bus.grant, 2'b00);
        chk_b("rst_s0_tready", bus.s0_tready, 1'b0);
        chk_b("rst_s1_tready", bus.s1_tready, 1'b0);
        chk_b("rst_core_in_tvalid", bus.core_in_tvalid, 1'b0);
        chk_b("rst_m0_tvalid", bus.m0_tvalid, 1'b0);
        chk_b("rst_m1_tvalid", bus.m1_tvalid, 1'b0);
        chk_b("rst_route_err", bus.route_err, 1'b0);

        // ---- keys gate the grant ----
        resetn = 1'b1;
        bus.s0_tvalid = 1'b1; bus.s0_tdata = CT[0]; bus.s0_tlast = 1'b0;
        bus.core_in_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_g("nokey_grant", bus.grant, 2'b00);
            chk_b("nokey_s0_tready", bus.s0_tready, 1'b0);
            chk_b("nokey_core_in_tvalid", bus.core_in_tvalid, 1'b0);
            tick();
        end
        bus.round_keys_valid = 1'b1;
        #1;
        chk_g("key_idle_grant", bus.grant, 2'b00);
        chk_b("key_idle_s0_tready", bus.s0_tready, 1'b0);
        tick();
        #1;
        chk_g("key_grant", bus.grant, 2'b01);
        chk_b("key_s0_tready", bus.s0_tready, 1'b1);
        chk_b("key_s1_tready", bus.s1_tready, 1'b0);
        chk_b("key_core_in_tvalid", bus.core_in_tvalid, 1'b1);
        chk_d("key_core_in_tdata", bus.core_in_tdata, CT[0]);
        tick();
        bus.s0_tdata = CT[1]; bus.s0_tlast = 1'b1;
        #1;
        chk_d("key_beat2_tdata", bus.core_in_tdata, CT[1]);
        chk_b("key_beat2_tlast", bus.core_in_tlast, 1'b1);
        tick();
        bus.s0_tvalid = 1'b0;
        #1;
        chk_g("key_release_grant", bus.grant, 2'b00);
        // return the two beats to m0
        bus.m0_tready = 1'b1; bus.m1_tready = 1'b1;
        bus.core_out_tvalid = 1'b1; bus.core_out_tdata = PT[0]; bus.core_out_tlast = 1'b0;
        #1;
        chk_b("ret_m0_tvalid", bus.m0_tvalid, 1'b1);
        chk_b("ret_m1_tvalid", bus.m1_tvalid, 1'b0);
        chk_d("ret_m0_tdata", bus.m0_tdata, PT[0]);
        chk_b("ret_core_out_tready", bus.core_out_tready, 1'b1);
        tick();
        bus.core_out_tdata = PT[1]; bus.core_out_tlast = 1'b1;
        #1;
        chk_b("ret2_m0_tvalid", bus.m0_tvalid, 1'b1);
        chk_b("ret2_m0_tlast", bus.m0_tlast, 1'b1);
        tick();
        bus.core_out_tvalid = 1'b0;
        #1;
        chk_b("ret_no_route_err", bus.route_err, 1'b0);

        // ---- round-robin with 2-beat packets ----
        do_reset();
        exp_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        bus.s0_tdata = 128'h00000000_00000000_00000000_0000aaaa;
        bus.s1_tdata = 128'h00000000_00000000_00000000_0000bbbb;
        bus.s0_tvalid = 1'b1; bus.s1_tvalid = 1'b1;
        bus.round_keys_valid = 1'b1; bus.core_in_tready = 1'b1;
        b0 = 0; b1 = 0;
        for (int i = 0; i < 8; i++) begin
            bus.s0_tlast = (b0 % 2) == 1;
            bus.s1_tlast = (b1 % 2) == 1;
            #1;
            chk_g("rr_grant", bus.grant, exp_g[i]);
            if (exp_g[i] == 2'b01) begin
                chk_d("rr_tdata_s0", bus.core_in_tdata, 128'h0000aaaa);
                chk_b("rr_s1_blocked", bus.s1_tready, 1'b0);
            end else if (exp_g[i] == 2'b10) begin
                chk_d("rr_tdata_s1", bus.core_in_tdata, 128'h0000bbbb);
                chk_b("rr_s0_blocked", bus.s0_tready, 1'b0);
            end
            a0 = bus.s0_tvalid & bus.s0_tready;
            a1 = bus.s1_tvalid & bus.s1_tready;
            if (i < 7) begin
                tick();
                if (a0) b0++;
                if (a1) b1++;
            end
        end
        bus.s0_tvalid = 1'b0; bus.s1_tvalid = 1'b0;
        exp_id = '{1'b0, 1'b0, 1'b1, 1'b1};
        bus.m0_tready = 1'b1; bus.m1_tready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            bus.core_out_tvalid = 1'b1;
            bus.core_out_tdata  = PT[j];
            #1;
            chk_b("rr_ret_m0_tvalid", bus.m0_tvalid, ~exp_id[j]);
            chk_b("rr_ret_m1_tvalid", bus.m1_tvalid, exp_id[j]);
            tick();
        end
        bus.core_out_tvalid = 1'b0;

        // ---- s1 4-beat packet with a key stall mid-packet ----
        do_reset();
        bus.s1_tvalid = 1'b1;
        bus.round_keys_valid = 1'b1; bus.core_in_tready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.s1_tdata = CT[k];
            bus.s1_tlast = (k == 3);
            if (k == 2) begin
                bus.round_keys_valid = 1'b0;
                #1;
                chk_b("stall_s1_tready", bus.s1_tready, 1'b0);
                chk_b("stall_core_in_tvalid", bus.core_in_tvalid, 1'b0);
                chk_g("stall_grant", bus.grant, 2'b10);
                tick();
                bus.round_keys_valid = 1'b1;
            end
            #1;
            chk_g("s1_grant", bus.grant, 2'b10);
            chk_b("s1_tready", bus.s1_tready, 1'b1);
            chk_d("s1_core_in_tdata", bus.core_in_tdata, CT[k]);
            tick();
        end
        bus.s1_tvalid = 1'b0;
        bus.m0_tready = 1'b1; bus.m1_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.core_out_tvalid = 1'b1;
            bus.core_out_tdata  = PT[k];
            bus.core_out_tlast  = (k == 3);
            #1;
            chk_b("s1_ret_m1_tvalid", bus.m1_tvalid, 1'b1);
            chk_b("s1_ret_m0_tvalid", bus.m0_tvalid, 1'b0);
            chk_d("s1_ret_m1_tdata", bus.m1_tdata, PT[k]);
            chk_b("s1_ret_m1_tlast", bus.m1_tlast, k == 3);
            tick();
        end
        bus.core_out_tvalid = 1'b0; bus.core_out_tlast = 1'b0;

        // ---- FIFO full backpressure ----
        do_reset();
        bus.s0_tvalid = 1'b1; bus.s0_tlast = 1'b0;
        bus.round_keys_valid = 1'b1; bus.core_in_tready = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.s0_tvalid && bus.s0_tready) n_acc++;
            tick();
        end
        chk_d("full_accepted", 128'(n_acc), 128'd16);
        #1;
        chk_b("full_s0_tready", bus.s0_tready, 1'b0);
        chk_b("full_core_in_tvalid", bus.core_in_tvalid, 1'b0);
        chk_g("full_grant", bus.grant, 2'b01);
        bus.core_out_tvalid = 1'b1; bus.core_out_tdata = PT[2];
        #1;
        chk_b("full_m0_tvalid", bus.m0_tvalid, 1'b1);
        chk_b("full_core_out_blocked", bus.core_out_tready, 1'b0);
        tick();
        bus.m0_tready = 1'b1;
        #1;
        chk_b("full_pop_tready", bus.core_out_tready, 1'b1);
        chk_b("full_pop_cycle_s0_tready", bus.s0_tready, 1'b0);
        tick();
        bus.core_out_tvalid = 1'b0; bus.m0_tready = 1'b0;
        #1;
        chk_b("after_pop_s0_tready", bus.s0_tready, 1'b1);
        tick();
        bus.s0_tvalid = 1'b0;
        #1;
        chk_b("refull_s0_tready", bus.s0_tready, 1'b0);

        // ---- underrun flag ----
        do_reset();
        bus.core_out_tvalid = 1'b1; bus.core_out_tdata = PT[3];
        #1;
        chk_b("uf_core_out_tready", bus.core_out_tready, 1'b1);
        chk_b("uf_m0_tvalid", bus.m0_tvalid, 1'b0);
        chk_b("uf_m1_tvalid", bus.m1_tvalid, 1'b0);
        chk_b("uf_route_err_before", bus.route_err, 1'b0);
        tick();
        bus.core_out_tvalid = 1'b0;
        #1;
        chk_b("uf_route_err_set", bus.route_err, 1'b1);
        tick();
        tick();
        #1;
        chk_b("uf_route_err_sticky", bus.route_err, 1'b1);
        resetn = 1'b0;
        tick();
        #1;
        chk_b("uf_route_err_cleared", bus.route_err, 1'b0);
        resetn = 1'b1;

        // ---- reset mid-packet ----
        do_reset();
        bus.s0_tvalid = 1'b1; bus.s0_tlast = 1'b0; bus.s0_tdata = CT[0];
        bus.round_keys_valid = 1'b1; bus.core_in_tready = 1'b1;
        tick();
        tick();
        #1;
        chk_g("mid_grant_before", bus.grant, 2'b01);
        resetn = 1'b0;
        bus.core_out_tvalid = 1'b1; bus.m0_tready = 1'b0;
        tick();
        #1;
        chk_g("mid_rst_grant", bus.grant, 2'b00);
        chk_b("mid_rst_s0_tready", bus.s0_tready, 1'b0);
        chk_b("mid_rst_core_in_tvalid", bus.core_in_tvalid, 1'b0);
        chk_b("mid_rst_m0_tvalid", bus.m0_tvalid, 1'b0);
        chk_b("mid_rst_fifo_empty", bus.core_out_tready, 1'b1);
        bus.core_out_tvalid = 1'b0;
        bus.s0_tvalid = 1'b0;
        resetn = 1'b1;
        tick();
        #1;
        chk_b("mid_rst_route_err", bus.route_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
